// File: rtl/mem_arbiter_pkg.sv
// Shared types and line geometry for the cache-to-memory arbiter.
// Grant and state encodings are used by both the arbiter FSM and its burst adaptor.
package mem_arbiter_pkg;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Memory bursts always start on a 32-byte line boundary.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:5], 5'b00000};
    endfunction

endpackage

// File: rtl/mem_arbiter_line_burst_adaptor.sv
// Splits a 256-bit line into four 64-bit memory beats and reassembles read beats.
// One shift buffer serves both directions: writes shift out low beats, reads shift in at the top.
module line_burst_adaptor
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_write,
    input  logic [LINE_W-1:0] line_in,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [BEAT_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] line_out,
    output logic              done
);

    logic              active_r;
    logic [1:0]        beat_r;
    logic [LINE_W-1:0] buf_r;
    logic              accept_s;
    logic              last_beat_s;

    assign accept_s    = active_r & mem_resp;
    assign last_beat_s = (beat_r == 2'(BEATS - 1));
    assign done        = accept_s & last_beat_s;
    assign mem_wdata   = buf_r[BEAT_W-1:0];
    // Includes the beat arriving this cycle so the full line is usable on the done edge.
    assign line_out    = {mem_rdata, buf_r[LINE_W-1:BEAT_W]};

    // Beat counter, burst activity flag and shift/assembly buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_r <= 1'b0;
            beat_r   <= 2'd0;
            buf_r    <= '0;
        end else if (start) begin
            active_r <= 1'b1;
            beat_r   <= 2'd0;
            buf_r    <= op_write ? line_in : {LINE_W{1'b0}};
        end else if (accept_s) begin
            active_r <= ~last_beat_s;
            beat_r   <= beat_r + 2'd1;
            buf_r    <= {mem_rdata, buf_r[LINE_W-1:BEAT_W]};
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the burst memory port between I-cache and D-cache.
// One cache line per grant; the line is moved as four 64-bit beats by line_burst_adaptor.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [31:0]       i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    state_e            state_r;
    state_e            state_next_s;
    grant_e            last_grant_r;
    grant_e            win_s;
    logic              win_write_s;
    logic              d_req_s;
    logic              start_s;
    logic              burst_done_s;
    logic [LINE_W-1:0] line_s;
    logic              mem_read_r;
    logic              mem_write_r;
    logic              i_resp_r;
    logic              d_resp_r;
    logic [31:0]       mem_addr_r;
    logic [LINE_W-1:0] i_rdata_r;
    logic [LINE_W-1:0] d_rdata_r;

    assign d_req_s = d_read | d_write;

    // Round-robin winner: on a tie the requester not granted last time wins
    always_comb begin
        win_s = GRANT_I;
        if (i_read && d_req_s) begin
            win_s = (last_grant_r == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_req_s) begin
            win_s = GRANT_D;
        end else begin
            win_s = GRANT_I;
        end
        // A write-back outranks a simultaneous (illegal) D read.
        win_write_s = (win_s == GRANT_D) && d_write;
    end

    // Next-state logic; requests are sampled only in IDLE
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_read || d_req_s) begin
                    start_s      = 1'b1;
                    state_next_s = win_write_s ? WRITE : READ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ, WRITE: begin
                if (burst_done_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = state_r;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Arbiter state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Memory command strobes and completion pulses decoded from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            i_resp_r    <= 1'b0;
            d_resp_r    <= 1'b0;
        end else begin
            mem_read_r  <= (state_next_s == READ);
            mem_write_r <= (state_next_s == WRITE);
            i_resp_r    <= (state_next_s == DONE) && (last_grant_r == GRANT_I);
            d_resp_r    <= (state_next_s == DONE) && (last_grant_r == GRANT_D);
        end
    end

    // Grant and line-aligned address latched on leaving IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_r <= GRANT_I;
            mem_addr_r   <= 32'h0000_0000;
        end else if (start_s) begin
            last_grant_r <= win_s;
            mem_addr_r   <= line_align((win_s == GRANT_D) ? d_addr : i_addr);
        end
    end

    // Completed read lines go to the granted cache only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rdata_r <= '0;
            d_rdata_r <= '0;
        end else if (burst_done_s && (state_r == READ)) begin
            if (last_grant_r == GRANT_I) begin
                i_rdata_r <= line_s;
            end else begin
                d_rdata_r <= line_s;
            end
        end
    end

    line_burst_adaptor u_burst (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .op_write  (win_write_s),
        .line_in   (d_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp),
        .mem_wdata (mem_wdata),
        .line_out  (line_s),
        .done      (burst_done_s)
    );

    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign mem_addr  = mem_addr_r;
    assign i_resp    = i_resp_r;
    assign d_resp    = d_resp_r;
    assign i_rdata   = i_rdata_r;
    assign d_rdata   = d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: hand-computed addresses, beats and response timing.
module tb_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_read, d_read, d_write, mem_resp;
    logic [31:0]  i_addr, d_addr;
    logic [255:0] d_wdata;
    logic [63:0]  mem_rdata;
    logic [255:0] i_rdata, d_rdata;
    logic         i_resp, d_resp, mem_read, mem_write;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_wdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [63:0]  rbeats [4];
    logic [63:0]  wseen  [4];
    logic         stable_f, early_f;
    logic [255:0] line_a, line_b;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task apply_reset;
        rst = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = '0; mem_rdata = 64'h0;
        tick; tick;
        rst = 1'b1;
        tick;
    endtask

    // Serves four beats with 'gap' idle cycles before each; returns in the cycle after beat 3.
    task mem_burst(input int gap);
        logic [31:0] a0;
        a0 = mem_addr; stable_f = 1'b1; early_f = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                if (mem_addr !== a0 || (mem_read | mem_write) !== 1'b1) stable_f = 1'b0;
                if ((i_resp | d_resp) !== 1'b0) early_f = 1'b1;
                tick;
            end
            if (mem_addr !== a0 || (mem_read | mem_write) !== 1'b1) stable_f = 1'b0;
            if ((i_resp | d_resp) !== 1'b0) early_f = 1'b1;
            wseen[k] = mem_wdata;
            mem_resp = 1'b1; mem_rdata = rbeats[k];
            tick;
            mem_resp = 1'b0; mem_rdata = 64'h0;
        end
    endtask

    task test_reset;
        rst = 1'b0;
        i_read = 1'b1; d_read = 1'b1; d_write = 1'b0; mem_resp = 1'b1;
        i_addr = 32'h1234_5678; d_addr = 32'h8765_4321; d_wdata = {4{64'hFFFF_0000_FFFF_0000}};
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        tick; tick;
        total_cnt++; if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) $display("FAIL reset_strobes: got %b want 0000", {mem_read, mem_write, i_resp, d_resp}); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else pass_cnt++;
        total_cnt++; if (mem_wdata !== 64'h0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else pass_cnt++;
        total_cnt++; if (i_rdata !== 256'h0) $display("FAIL reset_i_rdata: got %h want 0", i_rdata); else pass_cnt++;
        total_cnt++; if (d_rdata !== 256'h0) $display("FAIL reset_d_rdata: got %h want 0", d_rdata); else pass_cnt++;
    endtask

    task test_single_iread;
        apply_reset;
        rbeats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        i_read = 1'b1; i_addr = 32'h0000_0064;
        total_cnt++; if (mem_read !== 1'b0) $display("FAIL iread_cycle0: mem_read got %b want 0", mem_read); else pass_cnt++;
        tick;
        total_cnt++; if (mem_read !== 1'b1) $display("FAIL iread_memread: got %b want 1", mem_read); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h0000_0060) $display("FAIL iread_addr: got %h want 00000060", mem_addr); else pass_cnt++;
        mem_burst(0);
        total_cnt++; if (early_f !== 1'b0) $display("FAIL iread_early_resp: got %b want 0", early_f); else pass_cnt++;
        total_cnt++; if (i_resp !== 1'b1) $display("FAIL iread_resp: got %b want 1", i_resp); else pass_cnt++;
        total_cnt++; if (i_rdata !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}) $display("FAIL iread_data: got %h", i_rdata); else pass_cnt++;
        total_cnt++; if ({d_resp, mem_read} !== 2'b00) $display("FAIL iread_done_other: got %b want 00", {d_resp, mem_read}); else pass_cnt++;
        i_read = 1'b0;
        tick;
        total_cnt++; if (i_resp !== 1'b0) $display("FAIL iread_resp_pulse: got %b want 0", i_resp); else pass_cnt++;
    endtask

    task test_tie_from_reset;
        apply_reset;
        line_a = {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002, 64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000};
        line_b = {64'hB3B3_0000_B3B3_0003, 64'hB2B2_0000_B2B2_0002, 64'hB1B1_0000_B1B1_0001, 64'hB0B0_0000_B0B0_0000};
        rbeats = '{line_a[63:0], line_a[127:64], line_a[191:128], line_a[255:192]};
        d_read = 1'b1; d_addr = 32'h0000_1234;
        i_read = 1'b1; i_addr = 32'h0000_2048;
        tick;
        total_cnt++; if (mem_addr !== 32'h0000_1220) $display("FAIL tie1_d_first: mem_addr got %h want 00001220", mem_addr); else pass_cnt++;
        mem_burst(0);
        total_cnt++; if ({d_resp, i_resp} !== 2'b10) $display("FAIL tie1_resp: {d,i} got %b want 10", {d_resp, i_resp}); else pass_cnt++;
        total_cnt++; if (d_rdata !== line_a) $display("FAIL tie1_d_data: got %h want %h", d_rdata, line_a); else pass_cnt++;
        d_read = 1'b0;
        tick;
        total_cnt++; if (mem_read !== 1'b0) $display("FAIL tie1_gap: mem_read got %b want 0", mem_read); else pass_cnt++;
        tick;
        total_cnt++; if ({mem_read, mem_addr} !== {1'b1, 32'h0000_2040}) $display("FAIL tie1_i_next: got %b %h want 1 00002040", mem_read, mem_addr); else pass_cnt++;
        rbeats = '{line_b[63:0], line_b[127:64], line_b[191:128], line_b[255:192]};
        mem_burst(0);
        total_cnt++; if (i_resp !== 1'b1) $display("FAIL tie1_i_resp: got %b want 1", i_resp); else pass_cnt++;
        total_cnt++; if (i_rdata !== line_b) $display("FAIL tie1_i_data: got %h want %h", i_rdata, line_b); else pass_cnt++;
        total_cnt++; if (d_rdata !== line_a) $display("FAIL tie1_d_kept: got %h want %h", d_rdata, line_a); else pass_cnt++;
        i_read = 1'b0;
        tick;
    endtask

    task test_write_back;
        d_write = 1'b1; d_addr = 32'h8000_0020;
        d_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        rbeats = '{64'h0, 64'h0, 64'h0, 64'h0};
        tick;
        total_cnt++; if ({mem_write, mem_read} !== 2'b10) $display("FAIL wb_strobes: {w,r} got %b want 10", {mem_write, mem_read}); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h8000_0020) $display("FAIL wb_addr: got %h want 80000020", mem_addr); else pass_cnt++;
        mem_burst(1);
        total_cnt++; if (wseen[0] !== 64'hAAAA_AAAA_AAAA_AAAA) $display("FAIL wb_beat0: got %h want AAAA..", wseen[0]); else pass_cnt++;
        total_cnt++; if (wseen[1] !== 64'hBBBB_BBBB_BBBB_BBBB) $display("FAIL wb_beat1: got %h want BBBB..", wseen[1]); else pass_cnt++;
        total_cnt++; if (wseen[2] !== 64'hCCCC_CCCC_CCCC_CCCC) $display("FAIL wb_beat2: got %h want CCCC..", wseen[2]); else pass_cnt++;
        total_cnt++; if (wseen[3] !== 64'hDDDD_DDDD_DDDD_DDDD) $display("FAIL wb_beat3: got %h want DDDD..", wseen[3]); else pass_cnt++;
        total_cnt++; if ({d_resp, i_resp, mem_write} !== 3'b100) $display("FAIL wb_done: {d,i,w} got %b want 100", {d_resp, i_resp, mem_write}); else pass_cnt++;
        total_cnt++; if (d_rdata !== line_a) $display("FAIL wb_d_rdata_kept: got %h want %h", d_rdata, line_a); else pass_cnt++;
        d_write = 1'b0;
        tick;
        total_cnt++; if (d_resp !== 1'b0) $display("FAIL wb_resp_pulse: got %b want 0", d_resp); else pass_cnt++;
    endtask

    task test_second_tie;
        // D was granted last, so this tie belongs to I.
        i_read = 1'b1; i_addr = 32'h0000_3000;
        d_read = 1'b1; d_addr = 32'h0000_4010;
        rbeats = '{64'h0C00, 64'h0C01, 64'h0C02, 64'h0C03};
        tick;
        total_cnt++; if (mem_addr !== 32'h0000_3000) $display("FAIL tie2_i_first: mem_addr got %h want 00003000", mem_addr); else pass_cnt++;
        mem_burst(0);
        total_cnt++; if ({i_resp, d_resp} !== 2'b10) $display("FAIL tie2_resp: {i,d} got %b want 10", {i_resp, d_resp}); else pass_cnt++;
        total_cnt++; if (i_rdata !== {64'h0C03, 64'h0C02, 64'h0C01, 64'h0C00}) $display("FAIL tie2_i_data: got %h", i_rdata); else pass_cnt++;
        i_read = 1'b0;
        tick; tick;
        total_cnt++; if ({mem_read, mem_addr} !== {1'b1, 32'h0000_4000}) $display("FAIL tie2_d_next: got %b %h want 1 00004000", mem_read, mem_addr); else pass_cnt++;
        rbeats = '{64'h0D00, 64'h0D01, 64'h0D02, 64'h0D03};
        mem_burst(0);
        total_cnt++; if (d_rdata !== {64'h0D03, 64'h0D02, 64'h0D01, 64'h0D00}) $display("FAIL tie2_d_data: got %h", d_rdata); else pass_cnt++;
        d_read = 1'b0;
        tick;
    endtask

    task test_stall;
        i_read = 1'b1; i_addr = 32'h0000_0ABC;
        rbeats = '{64'h5000_0000_0000_0005, 64'h6000_0000_0000_0006, 64'h7000_0000_0000_0007, 64'h8000_0000_0000_0008};
        tick;
        mem_burst(2);
        total_cnt++; if (stable_f !== 1'b1) $display("FAIL stall_stable: got %b want 1", stable_f); else pass_cnt++;
        total_cnt++; if (early_f !== 1'b0) $display("FAIL stall_early_resp: got %b want 0", early_f); else pass_cnt++;
        total_cnt++; if ({i_resp, mem_addr} !== {1'b1, 32'h0000_0AA0}) $display("FAIL stall_resp: got %b %h want 1 00000aa0", i_resp, mem_addr); else pass_cnt++;
        total_cnt++; if (i_rdata !== {64'h8000_0000_0000_0008, 64'h7000_0000_0000_0007, 64'h6000_0000_0000_0006, 64'h5000_0000_0000_0005}) $display("FAIL stall_data: got %h", i_rdata); else pass_cnt++;
        i_read = 1'b0;
        tick;
    endtask

    task test_spurious;
        mem_resp = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick;
        mem_resp = 1'b0; mem_rdata = 64'h0;
        total_cnt++; if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) $display("FAIL spur_idle1: got %b want 0000", {mem_read, mem_write, i_resp, d_resp}); else pass_cnt++;
        tick;
        total_cnt++; if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) $display("FAIL spur_idle2: got %b want 0000", {mem_read, mem_write, i_resp, d_resp}); else pass_cnt++;
        i_read = 1'b1; i_addr = 32'h0000_0200;
        rbeats = '{64'h91, 64'h92, 64'h93, 64'h94};
        tick;
        mem_burst(0);
        total_cnt++; if ({early_f, i_resp} !== 2'b01) $display("FAIL spur_read_timing: {early,resp} got %b want 01", {early_f, i_resp}); else pass_cnt++;
        total_cnt++; if (i_rdata !== {64'h94, 64'h93, 64'h92, 64'h91}) $display("FAIL spur_read_data: got %h", i_rdata); else pass_cnt++;
        i_read = 1'b0;
        tick;
    endtask

    task test_reset_mid_burst;
        d_read = 1'b1; d_addr = 32'h0000_0040;
        rbeats = '{64'hE0, 64'hE1, 64'hE2, 64'hE3};
        tick;
        for (int k = 0; k < 3; k++) begin
            mem_resp = 1'b1; mem_rdata = rbeats[k];
            tick;
        end
        mem_resp = 1'b0; mem_rdata = 64'h0;
        #2;
        rst = 1'b0;
        #1;
        total_cnt++; if (mem_read !== 1'b0) $display("FAIL rstmid_async_drop: mem_read got %b want 0", mem_read); else pass_cnt++;
        d_read = 1'b0;
        tick; tick;
        total_cnt++; if ({d_resp, d_rdata} !== {1'b0, 256'h0}) $display("FAIL rstmid_no_resp: d_resp %b d_rdata %h want 0", d_resp, d_rdata); else pass_cnt++;
        rst = 1'b1;
        tick;
        i_read = 1'b1; i_addr = 32'h0000_0100;
        rbeats = '{64'hF0, 64'hF1, 64'hF2, 64'hF3};
        tick;
        total_cnt++; if ({mem_read, mem_addr} !== {1'b1, 32'h0000_0100}) $display("FAIL rstmid_new_start: got %b %h want 1 00000100", mem_read, mem_addr); else pass_cnt++;
        mem_burst(0);
        total_cnt++; if ({early_f, i_resp} !== 2'b01) $display("FAIL rstmid_new_timing: {early,resp} got %b want 01", {early_f, i_resp}); else pass_cnt++;
        total_cnt++; if (i_rdata !== {64'hF3, 64'hF2, 64'hF1, 64'hF0}) $display("FAIL rstmid_new_data: got %h", i_rdata); else pass_cnt++;
        i_read = 1'b0;
        tick;
    endtask

    initial begin
        rst = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = '0; mem_rdata = 64'h0;
        test_reset;
        test_single_iread;
        test_tie_from_reset;
        test_write_back;
        test_second_tie;
        test_stall;
        test_spurious;
        test_reset_mid_burst;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
